coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
- Front-end stage that feeds newspaper_fsm.
- Conditions the raw coin-slot sensors (5-cent and 10-cent) into the one-cycle coinin code that newspaper_fsm consumes: 01 = 5 cents, 10 = 10 cents.
- Synchronises, debounces and validates coins.
- Rejects ambiguous coins, and coins inserted while the vending path is closed.
- Keeps a saturating count of accepted coins.

Parameters:
- DEB_CYCLES, 4, consecutive stable synchronised cycles required to qualify a press or a release (legal range 1..255).
- CNT_W, 8, width of coin_cnt.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- sense5  input  1  raw 5-cent slot sensor, asynchronous to clk, active high.
- sense10  input  1  raw 10-cent slot sensor, asynchronous to clk, active high.
- accept_en  input  1  downstream allows coins; sampled only at qualification.
- coinin  output  2  one-cycle coin code to newspaper_fsm: 00 none, 01 5 cents, 10 10 cents; 11 never driven.
- reject  output  1  one-cycle pulse that drives the coin-return gate.
- coin_cnt  output  CNT_W  accepted-coin count, saturating.

Behaviour:
Synchronisers
- Each sensor passes through a two-flop synchroniser: s5, s10.
- Only s5 and s10 feed the FSM.

Reset (rst low, asynchronous)
- All flops cleared; state = IDLE.
- coinin = 00, reject = 0, coin_cnt = 0, debounce counter = 0.
- Outputs remain at reset values until the first clk edge after rst deasserts.

FSM states: IDLE, DEB, EMIT, REL.
- IDLE
  - s5 xor s10 high → DEB; latch the slot (kind = 5 or 10); counter = 1.
  - s5 and s10 both high → REL with reject pulsed in the following cycle.
  - Otherwise stay.
- DEB
  - Latched slot still high and other slot low: counter increments.
  - When the counter reaches DEB_CYCLES → EMIT.
  - Latched slot drops before reaching DEB_CYCLES → IDLE (glitch discarded, no output).
  - Other slot goes high → REL; reject pulsed one cycle.
- EMIT (exactly one cycle)
  - accept_en = 1: coinin = latched code; coin_cnt increments, holding at 2^CNT_W-1.
  - accept_en = 0: reject = 1; coinin stays 00; coin_cnt unchanged.
  - Next state REL.
- REL
  - Counter cleared on entry.
  - Counts consecutive cycles with s5 = 0 and s10 = 0; any high resets the counter to 0.
  - Counter reaches DEB_CYCLES → IDLE.
  - No new coin is recognised while in REL.

Outputs
- coinin and reject are registered.
- Each is high for exactly one cycle per event, and they are never high in the same cycle.

Latency
- Raw rise first sampled at edge 1 gives s high after edge 2.
- DEB is entered at edge 3, EMIT at edge DEB_CYCLES+2.
- coinin is valid for the cycle after edge DEB_CYCLES+2 (6 cycles for DEB_CYCLES=4).

Boundary conditions
- Glitch shorter than DEB_CYCLES synchronised cycles: no coinin, no reject.
- Both sensors rising on the same sampled edge: reject, no count.
- accept_en toggling during DEB has no effect; only its value in the EMIT cycle matters.
- Sensor held high indefinitely: exactly one event; the FSM stays in REL until release.
- rst asserted mid-DEB/EMIT/REL: immediate return to IDLE, outputs cleared, coin_cnt cleared, pending coin lost.
- coin_cnt at maximum: further accepts still emit coinin; count holds.

Test Plan (DEB_CYCLES=4, CNT_W=8):
- Reset, then sense5 high for 10 cycles → coinin = 01 for exactly one cycle, 6 cycles after the rise; coin_cnt = 1; reject stays 0.
- sense10 high for 10 cycles, release for ≥8 cycles, then sense5 high for 10 cycles → coinin 10 then 01 as two separate pulses; coin_cnt = 2.
- sense5 high for 3 cycles then low → no coinin, no reject; FSM back in IDLE; coin_cnt unchanged.
- sense5 and sense10 rise together, or sense10 rises 2 cycles into a sense5 debounce → one reject pulse, coinin stays 00, coin_cnt unchanged.
- accept_en = 0 with sense10 held for 10 cycles → reject pulse in the EMIT cycle, coinin 00; then accept_en = 1 and a new coin → accepted.
- rst pulsed low for 1 cycle during DEB → outputs and coin_cnt cleared immediately, no coinin; subsequent coin is accepted normally.
- Preload via 255 accepts → coin_cnt = 255; a 256th coin still emits coinin = 01 and coin_cnt stays 255.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces the 5/10-cent sensors and
// turns each qualified coin into a one-cycle coinin code or a reject pulse.
module coin_acceptor #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sense5,
    input  logic             sense10,
    input  logic             accept_en,
    output logic [1:0]       coinin,
    output logic             reject,
    output logic [CNT_W-1:0] coin_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEB  = 2'd1,
        EMIT = 2'd2,
        REL  = 2'd3
    } state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES);

    logic [1:0]       sync5_q, sync10_q;
    logic             s5, s10;
    state_t           state_q, state_d;
    logic             kind_q, kind_d;
    logic [7:0]       deb_q, deb_d, deb_inc;
    logic [1:0]       coinin_q, coinin_d;
    logic             reject_q, reject_d;
    logic [CNT_W-1:0] coin_cnt_q, coin_cnt_d;
    logic             qualify;
    logic             lat_hi, oth_hi;

    assign s5  = sync5_q[1];
    assign s10 = sync10_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync5_q    <= 2'b00;
            sync10_q   <= 2'b00;
            state_q    <= IDLE;
            kind_q     <= 1'b0;
            deb_q      <= 8'd0;
            coinin_q   <= 2'b00;
            reject_q   <= 1'b0;
            coin_cnt_q <= '0;
        end else begin
            sync5_q    <= {sync5_q[0], sense5};
            sync10_q   <= {sync10_q[0], sense10};
            state_q    <= state_d;
            kind_q     <= kind_d;
            deb_q      <= deb_d;
            coinin_q   <= coinin_d;
            reject_q   <= reject_d;
            coin_cnt_q <= coin_cnt_d;
        end
    end

    // kind: 0 = 5-cent slot latched, 1 = 10-cent slot latched
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        deb_d      = deb_q;
        coinin_d   = 2'b00;
        reject_d   = 1'b0;
        coin_cnt_d = coin_cnt_q;
        qualify    = 1'b0;
        deb_inc    = deb_q + 8'd1;
        lat_hi     = kind_q ? s10 : s5;
        oth_hi     = kind_q ? s5 : s10;

        unique case (state_q)
            IDLE: begin
                if (s5 && s10) begin
                    state_d  = REL;
                    deb_d    = 8'd0;
                    reject_d = 1'b1;
                end else if (s5 ^ s10) begin
                    kind_d = s10;
                    deb_d  = 8'd1;
                    if (DEB_LAST == 8'd1) qualify = 1'b1;
                    else                  state_d = DEB;
                end
            end
            DEB: begin
                if (oth_hi) begin
                    state_d  = REL;
                    deb_d    = 8'd0;
                    reject_d = 1'b1;
                end else if (!lat_hi) begin
                    state_d = IDLE;
                    deb_d   = 8'd0;
                end else begin
                    deb_d = deb_inc;
                    if (deb_inc == DEB_LAST) qualify = 1'b1;
                end
            end
            EMIT: begin
                state_d = REL;
                deb_d   = 8'd0;
            end
            REL: begin
                if (s5 || s10) begin
                    deb_d = 8'd0;
                end else if (deb_inc == DEB_LAST) begin
                    state_d = IDLE;
                    deb_d   = 8'd0;
                end else begin
                    deb_d = deb_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so the EMIT-cycle pulse is decided on the edge entering EMIT.
        if (qualify) begin
            state_d = EMIT;
            if (accept_en) begin
                coinin_d = kind_d ? 2'b10 : 2'b01;
                if (coin_cnt_q != {CNT_W{1'b1}}) coin_cnt_d = coin_cnt_q + 1'b1;
            end else begin
                reject_d = 1'b1;
            end
        end
    end

    assign coinin   = coinin_q;
    assign reject   = reject_q;
    assign coin_cnt = coin_cnt_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor (DEB_CYCLES=4, CNT_W=8).
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sense5 = 1'b0;
    logic       sense10 = 1'b0;
    logic       accept_en = 1'b1;
    logic [1:0] coinin;
    logic       reject;
    logic [7:0] coin_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    coin_acceptor #(.DEB_CYCLES(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sense5    (sense5),
        .sense10   (sense10),
        .accept_en (accept_en),
        .coinin    (coinin),
        .reject    (reject),
        .coin_cnt  (coin_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One coin episode. Sensors go high before edge 1; ci_tick/rj_tick give the
    // tick (counted after each edge) on which coinin/reject must be high; 0 = never.
    task automatic run(input string tag, input logic a5, input logic a10, input int d10,
                       input int hold, input int rel, input bit tog,
                       input int ci_tick, input logic [1:0] ci, input int rj_tick);
        logic ae_keep;
        ae_keep = accept_en;
        sense5  = a5;
        sense10 = a10 && (d10 == 0);
        for (int i = 1; i <= hold + rel; i++) begin
            tick();
            chk({tag, "_coinin"}, 32'(coinin), (i == ci_tick) ? 32'(ci) : 32'd0);
            chk({tag, "_reject"}, 32'(reject), (i == rj_tick) ? 32'd1 : 32'd0);
            if (a10 && d10 != 0 && i == d10) sense10 = 1'b1;
            if (tog && i < 5) accept_en = ~accept_en;
            if (i == hold) begin
                sense5  = 1'b0;
                sense10 = 1'b0;
            end
        end
        accept_en = ae_keep;
    endtask

    initial begin
        // Reset state while rst is low
        #3;
        chk("rst_coinin", 32'(coinin), 32'd0);
        chk("rst_reject", 32'(reject), 32'd0);
        chk("rst_cnt", 32'(coin_cnt), 32'd0);
        #9 rst = 1'b1;
        tick();
        chk("idle_coinin", 32'(coinin), 32'd0);

        run("c5", 1, 0, 0, 10, 8, 0, 6, 2'b01, 0);
        chk("c5_cnt", 32'(coin_cnt), 32'd1);

        run("c10", 0, 1, 0, 10, 8, 0, 6, 2'b10, 0);
        chk("c10_cnt", 32'(coin_cnt), 32'd2);
        run("c5b", 1, 0, 0, 10, 8, 0, 6, 2'b01, 0);
        chk("c5b_cnt", 32'(coin_cnt), 32'd3);

        run("glitch", 1, 0, 0, 3, 8, 0, 0, 2'b00, 0);
        chk("glitch_cnt", 32'(coin_cnt), 32'd3);

        run("both", 1, 1, 0, 10, 8, 0, 0, 2'b00, 3);
        chk("both_cnt", 32'(coin_cnt), 32'd3);

        run("late10", 1, 1, 2, 10, 8, 0, 0, 2'b00, 5);
        chk("late10_cnt", 32'(coin_cnt), 32'd3);

        accept_en = 1'b0;
        run("closed", 0, 1, 0, 10, 8, 0, 0, 2'b00, 6);
        chk("closed_cnt", 32'(coin_cnt), 32'd3);
        accept_en = 1'b1;
        run("toggle", 0, 1, 0, 10, 8, 1, 6, 2'b10, 0);
        chk("toggle_cnt", 32'(coin_cnt), 32'd4);

        // Asynchronous reset in the middle of a debounce
        sense5 = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b0;
        #1;
        chk("midrst_coinin", 32'(coinin), 32'd0);
        chk("midrst_reject", 32'(reject), 32'd0);
        chk("midrst_cnt", 32'(coin_cnt), 32'd0);
        sense5 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run("lost", 0, 0, 0, 1, 8, 0, 0, 2'b00, 0);
        chk("lost_cnt", 32'(coin_cnt), 32'd0);
        run("after_rst", 1, 0, 0, 10, 8, 0, 6, 2'b01, 0);
        chk("after_rst_cnt", 32'(coin_cnt), 32'd1);

        // Fill to saturation, then one more accept
        for (int k = 0; k < 254; k++) run("fill", 1, 0, 0, 6, 6, 0, 6, 2'b01, 0);
        chk("full_cnt", 32'(coin_cnt), 32'd255);
        run("sat", 1, 0, 0, 10, 8, 0, 6, 2'b01, 0);
        chk("sat_cnt", 32'(coin_cnt), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
